// File: rtl/cacheline_arbiter.sv
// ---------------------------------------------------------------------------
// cacheline_arbiter
//
// Shares the single physical-memory cacheline port between the instruction
// cache (I-side, read-only) and the data cache (D-side, read/write). One
// request is serviced at a time, to completion. When both sides are waiting
// in the same cycle, the side that was *not* granted last time wins. A steady
// stream of D-side misses therefore cannot starve instruction fetch.
//
// Handshake: a requester raises its read/write strobe and holds it, along
// with address/wdata, until it sees its one-cycle resp pulse. The arbiter
// samples the strobes only in IDLE. It latches op/address/wdata at the
// grant, so requester inputs are ignored while it is serving. Downstream,
// mem_read/mem_write stay high until the one-cycle mem_resp pulse. The
// requester's resp/rdata are driven combinationally from mem_resp in that
// same cycle. After every completion there is exactly one IDLE turnaround
// cycle, so a requester that still holds its strobe during the resp cycle is
// not served twice.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_pmem_read       I-cache line read request (held until i_pmem_resp)
//   i_pmem_address    I-cache line address
//   i_pmem_rdata      line returned to I-cache (0 unless i_pmem_resp)
//   i_pmem_resp       one-cycle completion pulse to I-cache
//   d_pmem_read       D-cache line read request (held until d_pmem_resp)
//   d_pmem_write      D-cache writeback request (held until d_pmem_resp)
//   d_pmem_address    D-cache line address
//   d_pmem_wdata      D-cache writeback line
//   d_pmem_rdata      line returned to D-cache (0 unless read completion)
//   d_pmem_resp       one-cycle completion pulse to D-cache
//   mem_read          downstream read request
//   mem_write         downstream write request
//   mem_address       downstream address
//   mem_wdata         downstream write line (0 for reads)
//   mem_rdata         downstream read line, valid with mem_resp
//   mem_resp          downstream one-cycle completion pulse
//   dbg_state_o       current FSM state (0 IDLE, 1 SERVE_I, 2 SERVE_D)
// ---------------------------------------------------------------------------
module cacheline_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    state_e                  state_q,      state_d;
    grant_e                  last_grant_q, last_grant_d;
    op_e                     op_q,         op_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q,      wdata_d;

    logic i_req;
    logic d_req;
    logic pick_d;
    logic serve_i;
    logic serve_d;

    // -----------------------------------------------------------------------
    // Grant decision and next-state logic
    // -----------------------------------------------------------------------
    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // D wins when it is alone. It also wins a tie when I had the last grant.
    // last_grant resets to I, so the first tie after reset goes to D.
    assign pick_d = d_req & (~i_req | (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d      = ST_SERVE_D;
                    last_grant_d = GRANT_D;
                    // Read+write together is illegal. The writeback wins so
                    // that a dirty line is never lost.
                    op_d         = d_pmem_write ? OP_WRITE : OP_READ;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_write ? d_pmem_wdata : '0;
                end else if (i_req) begin
                    state_d      = ST_SERVE_I;
                    last_grant_d = GRANT_I;
                    op_d         = OP_READ;
                    addr_d       = i_pmem_address;
                    wdata_d      = '0;
                end
            end

            ST_SERVE_I,
            ST_SERVE_D: begin
                if (mem_resp) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and latch registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_I;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The downstream outputs decode only the state and latch registers. They
    // therefore stay constant for a whole SERVE state and are all zero in IDLE.
    assign serve_i = (state_q == ST_SERVE_I);
    assign serve_d = (state_q == ST_SERVE_D);

    assign mem_read    = (serve_i | serve_d) & (op_q == OP_READ);
    assign mem_write   = serve_d & (op_q == OP_WRITE);
    assign mem_address = (serve_i | serve_d) ? addr_q : '0;
    assign mem_wdata   = (serve_d & (op_q == OP_WRITE)) ? wdata_q : '0;

    // Completion is passed straight through in the mem_resp cycle. A
    // mem_resp seen in IDLE matches no state decode, so it is dropped.
    assign i_pmem_resp  = serve_i & mem_resp;
    assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;

    assign d_pmem_resp  = serve_d & mem_resp;
    assign d_pmem_rdata = (d_pmem_resp & (op_q == OP_READ)) ? mem_rdata : '0;

    assign dbg_state_o = state_q;

    // The downstream port must never carry a read and a write together.
    a_no_read_write: assert property (@(posedge clk) disable iff (rst)
        !(mem_read && mem_write));

endmodule
